disp7seg_scan_ctrl: RTL and testbench

//  Time-multiplexing scan controller for a bank of NDIG 7-segment digits sharing one disp7seg decoder.
//  - Sequences one digit slot at a time: drives the 4-bit code into the shared decoder and selects the digit.
//  - Holds a guard interval with all digits off at the start of each slot, to suppress ghosting.
//  - Accepts new display values through a valid/ready handshake; updates commit only at frame boundaries (no tearing).
//  - Sits between the register/host side and the disp7seg decoder + digit drivers.

---
 rtl/disp7seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_disp7seg_scan_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp7seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp7seg_scan_ctrl
//
// Time-multiplexing scan controller for a bank of NDIG 7-segment digits that
// share one disp7seg decoder. One digit slot is active at a time: the slot's
// 4-bit code is presented on hex_code and the digit is selected on dig_en
// after a short all-off guard interval that suppresses ghosting. New display
// values arrive over a valid/ready handshake and are committed only at frame
// boundaries, so a frame never mixes old and new digits.
//
// Parameters
//   NDIG      number of digits scanned (>=1), digit 0 = least significant
//   PRESCALE  clk cycles per digit slot (>=2)
//   GUARD     cycles at slot start with dig_en=0 (1 <= GUARD < PRESCALE)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   scan enable; 0 = display dark, counters held at 0
//   lz_en       in   leading-zero blanking enable
//   load_valid  in   host offers a new value on load_data
//   load_data   in   digit codes, [4k+3:4k] = digit k
//   load_ready  out  controller can accept load_data
//   hex_code    out  code for the shared disp7seg decoder
//   dig_en      out  one-hot, active-high digit select
//   frame_tick  out  1-cycle pulse on the last cycle of the last slot
// ---------------------------------------------------------------------------
module disp7seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              lz_en,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  output logic [3:0]        hex_code,
  output logic [NDIG-1:0]   dig_en,
  output logic              frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [PW-1:0] PCNT_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_ON
  } slot_state_e;

  slot_state_e         state_q, state_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [4*NDIG-1:0]   active_q, active_d;
  logic [4*NDIG-1:0]   pending_q, pending_d;
  logic                load_ready_q, load_ready_d;
  logic [3:0]          hex_code_q, hex_code_d;
  logic [NDIG-1:0]     dig_en_q, dig_en_d;
  logic                frame_tick_q, frame_tick_d;
  logic [NDIG-1:0]     blank;

  // Next-state logic. Every registered output is computed from the next
  // counter/active values so that outputs line up with the counter state
  // they describe (hex_code changes on the same edge as dig).
  always_comb begin
    logic zero_above;

    state_d      = state_q;
    pcnt_d       = pcnt_q;
    dig_d        = dig_q;
    active_d     = active_q;
    pending_d    = pending_q;
    load_ready_d = load_ready_q;
    hex_code_d   = 4'h0;
    dig_en_d     = '0;
    frame_tick_d = 1'b0;
    blank        = '0;
    zero_above   = 1'b1;

    // A pending value (load_ready low) commits on the edge after frame_tick,
    // or immediately when scanning is disabled. A transfer and a commit can
    // never coincide because they require opposite load_ready states, so a
    // transfer during the frame_tick cycle waits for the next frame end.
    if (!load_ready_q && (!enable || frame_tick_q)) begin
      active_d     = pending_q;
      load_ready_d = 1'b1;
    end
    if (load_ready_q && load_valid) begin
      pending_d    = load_data;
      load_ready_d = 1'b0;
    end

    if (!enable) begin
      pcnt_d = '0;
      dig_d  = '0;
    end else if (pcnt_q == PCNT_MAX) begin
      pcnt_d = '0;
      dig_d  = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end

    // Slot FSM: leaving OFF lands on pcnt=1, which is already past the guard
    // when GUARD is 1.
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = (PCNT_ONE >= GUARD_END) ? ST_ON : ST_GUARD;
        ST_GUARD: state_d = (pcnt_d == GUARD_END) ? ST_ON : ST_GUARD;
        ST_ON:    state_d = (pcnt_d == '0) ? ST_GUARD : ST_ON;
        default:  state_d = ST_OFF;
      endcase
    end

    // Digit k is blanked when it and every digit above it are zero; the scan
    // runs from the top so zero_above carries that condition downwards.
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_d[4*k +: 4] == 4'h0);
      blank[k]   = lz_en && (k != 0) && zero_above;
    end

    for (int k = 0; k < NDIG; k++) begin
      if (dig_d == DW'(k)) begin
        hex_code_d  = active_d[4*k +: 4];
        dig_en_d[k] = (state_d == ST_ON) && !blank[k];
      end
    end

    frame_tick_d = enable && (pcnt_d == PCNT_MAX) && (dig_d == DIG_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      pcnt_q       <= '0;
      dig_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      load_ready_q <= 1'b1;
      hex_code_q   <= 4'h0;
      dig_en_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      dig_q        <= dig_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      load_ready_q <= load_ready_d;
      hex_code_q   <= hex_code_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign load_ready = load_ready_q;
  assign hex_code   = hex_code_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp7seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp7seg_scan_ctrl
//
// Bench for disp7seg_scan_ctrl with NDIG=4, PRESCALE=8, GUARD=2. The
// reference model describes the display by elapsed enabled cycles: slot
// position and digit follow from division/modulo of that count, and the
// expected digit select and code follow from the stored display value.
// ---------------------------------------------------------------------------
module tb_disp7seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int P    = 8;
  localparam int G    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lz_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  hex_code;
  logic [3:0]  dig_en;
  logic        frame_tick;

  disp7seg_scan_ctrl #(
    .NDIG    (NDIG),
    .PRESCALE(P),
    .GUARD   (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .lz_en     (lz_en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .hex_code  (hex_code),
    .dig_en    (dig_en),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_ft_prev;
  logic        exp_ready;
  logic [3:0]  exp_hex;
  logic [3:0]  exp_den;
  logic        exp_ft;

  typedef struct {
    bit          en;
    bit          lz;
    bit          lv;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  hex;
    logic [3:0]  den;
    logic        ft;
  } vec_t;

  vec_t vecs[12];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_t       = 0;
    m_active  = 16'h0;
    m_pend    = 16'h0;
    m_pv      = 1'b0;
    m_ft_prev = 1'b0;
    exp_ready = 1'b1;
    exp_hex   = 4'h0;
    exp_den   = 4'h0;
    exp_ft    = 1'b0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs held
  // during the cycle that just ended.
  function automatic void model_step();
    bit          had_pending;
    int          pc;
    int          dg;
    logic [15:0] upper;
    bit          blanked;

    had_pending = m_pv;
    if (had_pending && (!enable || m_ft_prev)) begin
      m_active = m_pend;
      m_pv     = 1'b0;
    end
    if (!had_pending && load_valid) begin
      m_pend = load_data;
      m_pv   = 1'b1;
    end

    m_t = enable ? m_t + 1 : 0;
    pc  = m_t % P;
    dg  = (m_t / P) % NDIG;

    upper   = m_active >> (4 * dg);
    blanked = lz_en && (dg > 0) && (upper == 16'h0);

    exp_ft    = enable && (pc == P - 1) && (dg == NDIG - 1);
    exp_hex   = upper[3:0];
    exp_den   = (enable && pc >= G && !blanked) ? (4'b0001 << dg) : 4'b0000;
    exp_ready = !m_pv;
    m_ft_prev = exp_ft;
  endfunction

  task automatic check_output(input string tag);
    compare({tag, ".load_ready"}, load_ready, exp_ready);
    compare({tag, ".hex_code"},   hex_code,   exp_hex);
    compare({tag, ".dig_en"},     dig_en,     exp_den);
    compare({tag, ".frame_tick"}, frame_tick, exp_ft);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output(tag);
  endtask

  task automatic apply_stimulus(input bit en, input bit lz, input bit lv, input logic [15:0] d);
    enable     = en;
    lz_en      = lz;
    load_valid = lv;
    load_data  = d;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    int          ft_count;
    logic [3:0]  den_or;
    logic [3:0]  hex_or;
    logic [15:0] d;

    // Directed start-up: load 0x1234 while disabled, then start scanning.
    vecs[0]  = '{0, 0, 1, 16'h1234, 0, 4'h0, 4'b0000, 0};
    vecs[1]  = '{0, 0, 0, 16'h0000, 1, 4'h4, 4'b0000, 0};
    vecs[2]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0000, 0};
    vecs[3]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[4]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[5]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[6]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[7]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[8]  = '{1, 0, 0, 16'h0000, 1, 4'h4, 4'b0001, 0};
    vecs[9]  = '{1, 0, 0, 16'h0000, 1, 4'h3, 4'b0000, 0};
    vecs[10] = '{1, 0, 0, 16'h0000, 1, 4'h3, 4'b0000, 0};
    vecs[11] = '{1, 0, 0, 16'h0000, 1, 4'h3, 4'b0010, 0};

    rst_n = 1'b0;
    apply_stimulus(0, 0, 0, 16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset.load_ready", load_ready, 1'b1);
    compare("reset.hex_code",   hex_code,   4'h0);
    compare("reset.dig_en",     dig_en,     4'h0);
    compare("reset.frame_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].lz, vecs[i].lv, vecs[i].data);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare($sformatf("vec%0d.load_ready", i), load_ready, vecs[i].rdy);
      compare($sformatf("vec%0d.hex_code", i),   hex_code,   vecs[i].hex);
      compare($sformatf("vec%0d.dig_en", i),     dig_en,     vecs[i].den);
      compare($sformatf("vec%0d.frame_tick", i), frame_tick, vecs[i].ft);
    end

    // Free-running scan: two frame pulses in any 64 enabled cycles.
    apply_stimulus(1, 0, 0, 16'h0);
    ft_count = 0;
    for (int i = 0; i < 64; i++) begin
      tick("scan");
      if (frame_tick === 1'b1) ft_count++;
    end
    compare("scan.frame_tick_count", ft_count, 2);

    // Mid-frame load of 0xABCD, then a second offer while busy.
    apply_stimulus(1, 0, 1, 16'hABCD);
    tick("load1");
    apply_stimulus(1, 0, 1, 16'h5555);
    for (int i = 0; i < 6; i++) tick("busy");
    apply_stimulus(1, 0, 0, 16'h0);
    for (int i = 0; i < 80; i++) tick("load1_run");

    // Transfer in the frame_tick cycle waits one full frame.
    n = 0;
    while (!exp_ft && n < 100) begin
      tick("seek_ft");
      n++;
    end
    compare("seek_ft.reached", frame_tick, 1'b1);
    apply_stimulus(1, 0, 1, 16'h9876);
    tick("ft_load");
    apply_stimulus(1, 0, 0, 16'h0);
    n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick("ft_wait");
      n++;
    end
    compare("ft_load.commit_latency", n, 32);
    for (int i = 0; i < 40; i++) tick("ft_run");

    // Leading-zero blanking with 0x0050, then 0x0000.
    apply_stimulus(1, 1, 1, 16'h0050);
    tick("lz_load");
    apply_stimulus(1, 1, 0, 16'h0);
    n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick("lz_wait");
      n++;
    end
    den_or = 4'h0;
    for (int i = 0; i < 32; i++) begin
      tick("lz_0050");
      den_or = den_or | dig_en;
    end
    compare("lz_0050.digits_lit", den_or, 4'b0011);
    apply_stimulus(1, 1, 1, 16'h0000);
    tick("lz_load0");
    apply_stimulus(1, 1, 0, 16'h0);
    n = 0;
    while (load_ready !== 1'b1 && n < 100) begin
      tick("lz_wait0");
      n++;
    end
    den_or = 4'h0;
    for (int i = 0; i < 32; i++) begin
      tick("lz_0000");
      den_or = den_or | dig_en;
    end
    compare("lz_0000.digits_lit", den_or, 4'b0001);

    // Disable in slot 2 with a load during the dark period, then re-enable.
    apply_stimulus(1, 0, 0, 16'h0);
    n = 0;
    while (((m_t / P) % NDIG) != 2 && n < 100) begin
      tick("seek_slot2");
      n++;
    end
    for (int i = 0; i < 3; i++) tick("slot2");
    apply_stimulus(0, 0, 0, 16'h0);
    tick("dis");
    apply_stimulus(0, 0, 1, 16'h4321);
    tick("dis_load");
    apply_stimulus(0, 0, 0, 16'h0);
    ft_count = 0;
    den_or   = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick("dis_run");
      den_or = den_or | dig_en;
      if (frame_tick === 1'b1) ft_count++;
    end
    compare("dis.frame_tick_count", ft_count, 0);
    compare("dis.digits_lit", den_or, 4'b0000);
    apply_stimulus(1, 0, 0, 16'h0);
    tick("reen");
    compare("reen.guard_dig_en", dig_en, 4'b0000);
    compare("reen.hex_code", hex_code, 4'h1);
    for (int i = 0; i < 40; i++) tick("reen_run");

    // Asynchronous reset mid-slot with a value pending.
    apply_stimulus(1, 0, 1, 16'hEEEE);
    tick("rst_load");
    apply_stimulus(1, 0, 0, 16'h0);
    tick("rst_pending");
    #2;
    rst_n = 1'b0;
    #1;
    compare("midrst.load_ready", load_ready, 1'b1);
    compare("midrst.hex_code",   hex_code,   4'h0);
    compare("midrst.dig_en",     dig_en,     4'h0);
    compare("midrst.frame_tick", frame_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hex_or = 4'h0;
    for (int i = 0; i < 40; i++) begin
      tick("post_rst");
      hex_or = hex_or | hex_code;
    end
    compare("post_rst.no_stale_code", hex_or, 4'h0);

    // Randomised traffic against the model.
    apply_stimulus(1, 0, 0, 16'h0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 2) lz_en = ~lz_en;
      for (int k = 0; k < 4; k++) begin
        d[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      load_data  = d;
      load_valid = ($urandom_range(0, 3) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
